// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem req/rvalid
// handshake (one outstanding request) and drives the IF/ID register.
module fetch_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pcsrc_e,
  input  logic [XLEN-1:0] pctarget_e,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_f, pc_f_n;
  logic [XLEN-1:0] pc_req, pc_req_n;
  logic [XLEN-1:0] pc_req_p4;
  logic            kill, kill_n;
  logic [31:0]     hold_instr, hold_n;
  logic            fwd;
  logic [31:0]     fwd_word;

  assign pc_req_p4 = pc_req + XLEN'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc_f       <= RESET_PC;
      pc_req     <= RESET_PC;
      kill       <= 1'b0;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_n;
      pc_f       <= pc_f_n;
      pc_req     <= pc_req_n;
      kill       <= kill_n;
      hold_instr <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_f_n    = pc_f;
    pc_req_n  = pc_req;
    kill_n    = kill;
    hold_n    = hold_instr;
    imem_req  = 1'b0;
    imem_addr = pc_f;
    fwd       = 1'b0;
    fwd_word  = imem_rdata;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (pcsrc_e) begin
          imem_addr = pctarget_e;
          pc_f_n    = pctarget_e;
        end
        if (imem_ready) begin
          pc_req_n = imem_addr;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          // a redirect seen now or earlier makes this word stale
          if (kill || pcsrc_e) begin
            kill_n  = 1'b0;
            state_n = REQ;
            if (pcsrc_e) pc_f_n = pctarget_e;
          end else begin
            pc_f_n = pc_req_p4;
            if (!stall_d && !flush_d) begin
              fwd     = 1'b1;
              state_n = REQ;
            end else begin
              hold_n  = imem_rdata;
              state_n = HOLD;
            end
          end
        end else if (pcsrc_e) begin
          pc_f_n = pctarget_e;
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (pcsrc_e) begin
          pc_f_n  = pctarget_e;
          state_n = REQ;
        end else if (!stall_d && !flush_d) begin
          fwd      = 1'b1;
          fwd_word = hold_instr;
          state_n  = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= '0;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall_d) begin
      if (fwd) begin
        instr_d   <= fwd_word;
        pc_d      <= pc_req;
        pcplus4_d <= pc_req_p4;
        valid_d   <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

endmodule
